// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe automatic player.
// Pure combinational constants/functions, no latency.
// No flow control; consumed by ttt_auto_player and ttt_line_eval.
package ttt_pkg;

    // Board game_state encoding
    localparam logic [1:0] GS_PLAY  = 2'b00;
    localparam logic [1:0] GS_X_WIN = 2'b01;
    localparam logic [1:0] GS_O_WIN = 2'b10;
    localparam logic [1:0] GS_DRAW  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE,
        ST_CONFIRM,
        ST_DONE
    } state_t;

    // The eight winning lines as triples of cell indices (idx = (row-1)*3 + (col-1))
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [1:0] idx_to_row(input logic [3:0] idx);
        return 2'(idx / 4'd3) + 2'd1;
    endfunction

    function automatic logic [1:0] idx_to_col(input logic [3:0] idx);
        return 2'(idx % 4'd3) + 2'd1;
    endfunction

    function automatic logic [3:0] rc_to_idx(input logic [1:0] row, input logic [1:0] col);
        return 4'(row - 2'd1) * 4'd3 + 4'(col - 2'd1);
    endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// Decides whether placing symbol 'sym' on cell 'idx' completes a winning line.
// Purely combinational, zero latency.
// No flow control. Ports: snap_valid/snap_symbol (board snapshot), idx, sym -> completes.
module ttt_line_eval
    import ttt_pkg::*;
(
    input  logic [8:0] snap_valid,
    input  logic [8:0] snap_symbol,
    input  logic [3:0] idx,
    input  logic       sym,
    output logic       completes
);

    logic       on_line;
    logic [1:0] same_cnt;

    // A line is completed when it passes through idx and its other two
    // cells are both occupied by sym.
    always_comb begin
        completes = 1'b0;
        on_line   = 1'b0;
        same_cnt  = 2'd0;
        for (int l = 0; l < 8; l++) begin
            on_line  = 1'b0;
            same_cnt = 2'd0;
            for (int p = 0; p < 3; p++) begin
                if (WIN_LINES[l][p] == idx) begin
                    on_line = 1'b1;
                end else if (snap_valid[WIN_LINES[l][p]] &&
                             (snap_symbol[WIN_LINES[l][p]] == sym)) begin
                    same_cnt = same_cnt + 2'd1;
                end
            end
            if (on_line && (same_cnt == 2'd2)) begin
                completes = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_auto_player.sv
// Machine opponent: on start snapshots the board, scans 9 cells, issues one set pulse, confirms.
// Latency: set at cycle 10, done at cycle 12 after start (cycle 1 on game-over/full reject).
// No backpressure: start is taken only in IDLE, otherwise dropped. Macro TTT_STRATEGY_EN enables
// win > block > centre > first-free priority; without it the lowest free cell is played.
// Ports: clk, reset (sync, high), start, board_valid/board_symbol/game_state in;
//        row, col, set, busy, done, error, move_idx out.
module ttt_auto_player
    import ttt_pkg::*;
#(
    parameter int CONFIRM_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] board_valid,
    input  logic [8:0] board_symbol,
    input  logic [1:0] game_state,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       set,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] move_idx
);

    localparam logic [3:0] TMO_LAST = 4'(CONFIRM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [8:0] snap_valid, snap_symbol;
    logic [3:0] scan_k;
    logic [3:0] best_idx, best_idx_nxt;
    logic [1:0] best_cls;
    logic       best_found;
    logic [3:0] tmo_cnt;
    logic       err_q;

    logic       own_sym;
    logic       reject;
    logic       cell_free;
    logic [1:0] cell_cls;
    logic       take;

    // Even number of occupied cells -> X (1) to move, matching the board.
    assign own_sym   = ~^snap_valid;
    assign reject    = (game_state != GS_PLAY) || (board_valid == 9'h1FF);
    assign cell_free = ~snap_valid[scan_k];

`ifdef TTT_STRATEGY_EN
    logic win_hit, blk_hit;

    ttt_line_eval u_win (
        .snap_valid (snap_valid),
        .snap_symbol(snap_symbol),
        .idx        (scan_k),
        .sym        (own_sym),
        .completes  (win_hit)
    );

    ttt_line_eval u_blk (
        .snap_valid (snap_valid),
        .snap_symbol(snap_symbol),
        .idx        (scan_k),
        .sym        (~own_sym),
        .completes  (blk_hit)
    );

    always_comb begin
        cell_cls = 2'd0;
        if (win_hit)              cell_cls = 2'd3;
        else if (blk_hit)         cell_cls = 2'd2;
        else if (scan_k == 4'd4)  cell_cls = 2'd1;
    end
`else
    // Symbols only matter to the line evaluator; unused in this build.
    logic unused_symbol;
    assign unused_symbol = ^snap_symbol;
    assign cell_cls      = 2'd0;
`endif

    // Strictly-higher update keeps the lowest index among equal classes.
    assign take         = cell_free && (!best_found || (cell_cls > best_cls));
    assign best_idx_nxt = take ? scan_k : best_idx;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = reject ? ST_DONE : ST_SCAN;
            ST_SCAN:    if (scan_k == 4'd8) state_nxt = ST_ISSUE;
            ST_ISSUE:   state_nxt = ST_CONFIRM;
            ST_CONFIRM: if (board_valid[best_idx] || (tmo_cnt == TMO_LAST)) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded straight from the state register
    always_comb begin
        set   = (state == ST_ISSUE);
        busy  = (state == ST_SCAN) || (state == ST_ISSUE) || (state == ST_CONFIRM);
        done  = (state == ST_DONE);
        error = (state == ST_DONE) && err_q;
    end

    // Snapshot, scan and confirm datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_valid  <= '0;
            snap_symbol <= '0;
            scan_k      <= '0;
            best_idx    <= '0;
            best_cls    <= '0;
            best_found  <= 1'b0;
            tmo_cnt     <= '0;
            err_q       <= 1'b0;
            row         <= '0;
            col         <= '0;
            move_idx    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        scan_k     <= '0;
                        best_idx   <= '0;
                        best_cls   <= '0;
                        best_found <= 1'b0;
                        err_q      <= reject;
                        if (!reject) begin
                            snap_valid  <= board_valid;
                            snap_symbol <= board_symbol;
                        end
                    end
                end
                ST_SCAN: begin
                    scan_k <= scan_k + 4'd1;
                    if (take) begin
                        best_idx   <= scan_k;
                        best_cls   <= cell_cls;
                        best_found <= 1'b1;
                    end
                    // Load the move outputs on the last scan cycle so they are valid in ISSUE.
                    if (scan_k == 4'd8) begin
                        move_idx <= best_idx_nxt;
                        row      <= idx_to_row(best_idx_nxt);
                        col      <= idx_to_col(best_idx_nxt);
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= '0;
                end
                ST_CONFIRM: begin
                    tmo_cnt <= tmo_cnt + 4'd1;
                    err_q   <= ~board_valid[best_idx];
                end
                default: ;
            endcase
        end
    end

endmodule
